vfifo_dual_queue_ctrl: RTL and testbench

VFIFO_DUAL_QUEUE_CTRL -- requirements
Module: vfifo_dual_queue_ctrl

---
 rtl/vfifo_pkg.sv | 25 ++
 rtl/vfifo_dual_queue_ctrl_if.sv | 31 +++
 rtl/vfifo_rr_arb2.sv | 34 +++
 rtl/vfifo_dual_queue_ctrl.sv | 142 ++++++++++++++
 tb/tb_vfifo_dual_queue_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/vfifo_pkg.sv
// Shared constants and pointer helpers for the dual-queue virtual FIFO.
// Imported by the interface, the arbiter and the controller top.
package vfifo_pkg;

  localparam int NUM_Q = 2;
  localparam int QID_W = 1;

  // Pointers carry one extra wrap bit above the index bits.
  // Full: only the wrap bit (bit aw-1) differs.
  function automatic logic ptr_full(
    input logic [31:0] wp,
    input logic [31:0] rp,
    input int          aw
  );
    return (wp ^ rp) == (32'h1 << (aw - 1));
  endfunction

  function automatic logic ptr_empty(
    input logic [31:0] wp,
    input logic [31:0] rp
  );
    return wp == rp;
  endfunction

endpackage

// File: rtl/vfifo_dual_queue_ctrl_if.sv
// Client-side bundle of the dual-queue FIFO controller.
// master = queue user, slave = controller.
interface vfifo_dual_queue_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  import vfifo_pkg::*;

  logic [NUM_Q-1:0]            wr_req;
  logic [NUM_Q*DATA_WIDTH-1:0] wr_dat;
  logic [NUM_Q-1:0]            wr_ack;
  logic [NUM_Q-1:0]            rd_req;
  logic [NUM_Q-1:0]            rd_ack;
  logic                        rd_vld;
  logic [QID_W-1:0]            rd_qid;
  logic [DATA_WIDTH-1:0]       rd_dat;
  logic [NUM_Q-1:0]            full;
  logic [NUM_Q-1:0]            empty;

  modport master (
    output wr_req, wr_dat, rd_req,
    input  wr_ack, rd_ack, rd_vld,
    input  rd_qid, rd_dat, full, empty
  );

  modport slave (
    input  wr_req, wr_dat, rd_req,
    output wr_ack, rd_ack, rd_vld,
    output rd_qid, rd_dat, full, empty
  );

endinterface

// File: rtl/vfifo_rr_arb2.sv
// Two-input round-robin arbiter with one-hot grant.
// On a tie the requester not granted last wins.
module vfifo_rr_arb2
  import vfifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_Q-1:0] elig,
  output logic [NUM_Q-1:0] gnt
);

  logic [QID_W-1:0] last_q;
  logic [QID_W-1:0] last_d;

  // grant selection and last-grant update
  always_comb begin
    gnt    = '0;
    last_d = last_q;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q[0] ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    if (|gnt) last_d = gnt[1];
  end

  // last-grant register, queue 1 after reset so queue 0 wins first tie
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/vfifo_dual_queue_ctrl.sv
// Two FIFOs sharing one dual-port RAM; address MSB selects the queue.
// Optional VFIFO_FILL_COUNT_EN adds a registered per-queue fill output.
module vfifo_dual_queue_ctrl
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  vfifo_dual_queue_ctrl_if.slave      bus,
`ifdef VFIFO_FILL_COUNT_EN
  output logic [NUM_Q*ADDR_WIDTH-1:0] fill,
`endif
  output logic [ADDR_WIDTH-1:0]       ram_adr_a,
  output logic [DATA_WIDTH-1:0]       ram_d_a,
  output logic                        ram_we_a,
  output logic [ADDR_WIDTH-1:0]       ram_adr_b,
  output logic [DATA_WIDTH-1:0]       ram_d_b,
  output logic                        ram_we_b,
  input  logic [DATA_WIDTH-1:0]       ram_q_b
);

  localparam int PW = ADDR_WIDTH - 1;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;

  ptr_t [NUM_Q-1:0] wptr_q, wptr_d;
  ptr_t [NUM_Q-1:0] rptr_q, rptr_d;

  logic [NUM_Q-1:0] full_q, full_d;
  logic [NUM_Q-1:0] empty_q, empty_d;
  logic             rd_vld_q, rd_vld_d;
  logic [QID_W-1:0] rd_qid_q, rd_qid_d;

  logic [NUM_Q-1:0] wr_elig, rd_elig;
  logic [NUM_Q-1:0] wr_gnt, rd_gnt;
  logic [QID_W-1:0] wr_sel, rd_sel;

  // no grants while in reset; status flags are registered
  assign wr_elig = bus.wr_req & ~full_q & {NUM_Q{~rst}};
  assign rd_elig = bus.rd_req & ~empty_q & {NUM_Q{~rst}};

  vfifo_rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .elig (wr_elig),
    .gnt  (wr_gnt)
  );

  vfifo_rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .elig (rd_elig),
    .gnt  (rd_gnt)
  );

  assign wr_sel = wr_gnt[1];
  assign rd_sel = rd_gnt[1];

  // RAM port A: write path of the granted queue
  always_comb begin
    ram_we_a  = |wr_gnt;
    ram_adr_a = {wr_sel, wptr_q[wr_sel][PW-1:0]};
    ram_d_a   = bus.wr_dat[wr_sel*DATA_WIDTH +: DATA_WIDTH];
  end

  // RAM port B: read-only, address of the granted queue
  always_comb begin
    ram_we_b  = 1'b0;
    ram_d_b   = '0;
    ram_adr_b = {rd_sel, rptr_q[rd_sel][PW-1:0]};
  end

  // pointer advance, status flags and read-valid pipeline
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = '0;
    empty_d = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (wr_gnt[q]) wptr_d[q] = wptr_q[q] + ptr_t'(1);
      if (rd_gnt[q]) rptr_d[q] = rptr_q[q] + ptr_t'(1);
      full_d[q]  = ptr_full(32'(wptr_d[q]),
                            32'(rptr_d[q]),
                            ADDR_WIDTH);
      empty_d[q] = ptr_empty(32'(wptr_d[q]),
                             32'(rptr_d[q]));
    end
    rd_vld_d = |rd_gnt;
    rd_qid_d = rd_sel;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      full_q   <= '0;
      empty_q  <= '1;
      rd_vld_q <= 1'b0;
      rd_qid_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      rd_vld_q <= rd_vld_d;
      rd_qid_q <= rd_qid_d;
    end
  end

`ifdef VFIFO_FILL_COUNT_EN
  ptr_t [NUM_Q-1:0] fill_q, fill_d;

  // occupancy follows the next pointers
  always_comb begin
    fill_d = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      fill_d[q] = wptr_d[q] - rptr_d[q];
    end
  end

  // fill register
  always_ff @(posedge clk) begin
    if (rst) fill_q <= '0;
    else     fill_q <= fill_d;
  end

  assign fill = fill_q;
`endif

  // rd_vld is masked in a reset cycle so a pending read is dropped
  assign bus.wr_ack = wr_gnt;
  assign bus.rd_ack = rd_gnt;
  assign bus.rd_vld = rd_vld_q & ~rst;
  assign bus.rd_qid = rd_qid_q;
  assign bus.rd_dat = ram_q_b;
  assign bus.full   = full_q;
  assign bus.empty  = empty_q;

endmodule

// File: tb/tb_vfifo_dual_queue_ctrl.sv
// Directed + random bench for vfifo_dual_queue_ctrl with a RAM model,
// a reference queue model and a read-data scoreboard.
module tb_vfifo_dual_queue_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << (AW - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vfifo_dual_queue_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic [AW-1:0]     ram_adr_a, ram_adr_b;
  logic [DW-1:0]     ram_d_a, ram_d_b, ram_q_b;
  logic              ram_we_a, ram_we_b;
`ifdef VFIFO_FILL_COUNT_EN
  logic [2*AW-1:0]   fill;
`endif

  vfifo_dual_queue_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
`ifdef VFIFO_FILL_COUNT_EN
    .fill      (fill),
`endif
    .ram_adr_a (ram_adr_a),
    .ram_d_a   (ram_d_a),
    .ram_we_a  (ram_we_a),
    .ram_adr_b (ram_adr_b),
    .ram_d_b   (ram_d_b),
    .ram_we_b  (ram_we_b),
    .ram_q_b   (ram_q_b)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  int checks = 0;
  int errors = 0;

  int   cnt [2];
  int   wp  [2];
  int   rp  [2];
  logic wl, rl;
  bit   pend;
  logic [DW-1:0] mq0 [$];
  logic [DW-1:0] mq1 [$];
  logic [DW:0]   sb  [$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] arb(input logic [1:0] e,
                                     input logic last);
    case (e)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    for (int q = 0; q < 2; q++) begin
      cnt[q] = 0; wp[q] = 0; rp[q] = 0;
    end
    wl = 1'b1; rl = 1'b1; pend = 0;
    mq0.delete(); mq1.delete(); sb.delete();
  endtask

  task automatic cyc(input logic r,
                     input logic [1:0] wr,
                     input logic [2*DW-1:0] wd,
                     input logic [1:0] rd);
    logic [1:0] ew, er, we_el, re_el;
    logic [DW:0] e;
    logic [DW-1:0] d;
    logic [AW-1:0] ea;
    int q;
    @(negedge clk);
    rst = r;
    bus.wr_req = wr;
    bus.wr_dat = wd;
    bus.rd_req = rd;
    #1;
    chk("rd_vld", bus.rd_vld, pend && !r);
    if (pend) begin
      e = sb.pop_front();
      if (!r) begin
        chk("rd_qid", bus.rd_qid, e[DW]);
        chk("rd_dat", bus.rd_dat, e[DW-1:0]);
      end
    end
    chk("full", bus.full, {cnt[1] == DEPTH, cnt[0] == DEPTH});
    chk("empty", bus.empty, {cnt[1] == 0, cnt[0] == 0});
`ifdef VFIFO_FILL_COUNT_EN
    chk("fill", fill, {AW'(cnt[1]), AW'(cnt[0])});
`endif
    for (int i = 0; i < 2; i++) begin
      we_el[i] = wr[i] && cnt[i] < DEPTH;
      re_el[i] = rd[i] && cnt[i] > 0;
    end
    ew = r ? 2'b00 : arb(we_el, wl);
    er = r ? 2'b00 : arb(re_el, rl);
    chk("wr_ack", bus.wr_ack, ew);
    chk("rd_ack", bus.rd_ack, er);
    chk("ram_we_a", ram_we_a, |ew);
    chk("ram_we_b", ram_we_b, 1'b0);
    chk("ram_d_b", ram_d_b, '0);
    if (|ew) begin
      q  = ew[1] ? 1 : 0;
      ea = AW'(q * DEPTH + (wp[q] % DEPTH));
      d  = q ? wd[2*DW-1:DW] : wd[DW-1:0];
      chk("ram_adr_a", ram_adr_a, ea);
      chk("ram_d_a", ram_d_a, d);
      if (q == 1) mq1.push_back(d);
      else        mq0.push_back(d);
      cnt[q]++;
      wp[q] = (wp[q] + 1) % (2 * DEPTH);
      wl = q[0];
    end
    if (|er) begin
      q  = er[1] ? 1 : 0;
      ea = AW'(q * DEPTH + (rp[q] % DEPTH));
      chk("ram_adr_b", ram_adr_b, ea);
      d = (q == 1) ? mq1.pop_front() : mq0.pop_front();
      sb.push_back({q[0], d});
      cnt[q]--;
      rp[q] = (rp[q] + 1) % (2 * DEPTH);
      rl = q[0];
    end
    pend = |er;
    if (r) model_reset();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    bus.wr_req = '0;
    bus.wr_dat = '0;
    bus.rd_req = '0;
    repeat (2) @(posedge clk);

    // reset state
    cyc(0, 2'b00, '0, 2'b00);
    chk("rd_qid_rst", bus.rd_qid, 1'b0);

    // fill queue 0 to full; queue 1 stays empty
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 2'b01, {32'h0, 32'h1000 + 32'(i)}, 2'b00);
    cyc(0, 2'b01, {32'h0, 32'hdead}, 2'b00);
    chk("full0", bus.full[0], 1'b1);
    chk("empty1", bus.empty[1], 1'b1);

    // write refused, read granted on a full queue
    cyc(0, 2'b01, {32'h0, 32'hbeef}, 2'b01);
    cyc(0, 2'b00, '0, 2'b00);
    chk("full0_clr", bus.full[0], 1'b0);

    // drain queue 0 past empty
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 2'b00, '0, 2'b01);
    cyc(0, 2'b00, '0, 2'b01);

    // write+read on empty queue: only the write goes
    cyc(0, 2'b01, {32'h0, 32'h5a5a}, 2'b01);
    cyc(0, 2'b00, '0, 2'b01);
    cyc(0, 2'b00, '0, 2'b00);

    // round-robin write on both queues from reset
    cyc(1, 2'b00, '0, 2'b00);
    for (int i = 0; i < 4; i++)
      cyc(0, 2'b11, {32'hb0 + 32'(i), 32'ha0 + 32'(i)}, 2'b00);

    // write 0xA5 to queue 1, read it back
    cyc(1, 2'b00, '0, 2'b00);
    cyc(0, 2'b10, {32'ha5, 32'h0}, 2'b00);
    cyc(0, 2'b00, '0, 2'b10);
    cyc(0, 2'b00, '0, 2'b00);

    // random mix
    for (int i = 0; i < 400; i++)
      cyc(0, 2'($urandom_range(0, 3)),
          {$urandom, $urandom},
          2'($urandom_range(0, 3)));

    // reset right after a read grant
    cyc(1, 2'b00, '0, 2'b00);
    cyc(0, 2'b01, {32'h0, 32'h77}, 2'b00);
    cyc(0, 2'b00, '0, 2'b01);
    cyc(1, 2'b11, {32'h1, 32'h2}, 2'b11);
    cyc(1, 2'b11, {32'h1, 32'h2}, 2'b11);
    cyc(0, 2'b00, '0, 2'b00);
    chk("rst_empty", bus.empty, 2'b11);
    chk("rst_full", bus.full, 2'b00);
    cyc(0, 2'b00, '0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
